// File: rtl/pio_in_pkg.sv
`default_nettype none
// =====================================================================
// pio_in_pkg : register map, edge-type codes and helpers for the
//              edge-capturing input PIO.
// Revision   : 1.0
// =====================================================================
package pio_in_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Start-up sequence of each input bit: wait for both synchroniser
   // stages to hold real samples before adopting the pin value.
   typedef enum logic [1:0] {
      PRIME_S1   = 2'd0,
      PRIME_S2   = 2'd1,
      PRIME_LOAD = 2'd2,
      PRIME_RUN  = 2'd3
   } prime_state_e;

   typedef struct packed {
      logic mask;
      logic cap;
   } wr_dec_t;

   function automatic wr_dec_t wr_decode(input logic       cs,
                                         input logic       wr_n,
                                         input logic [1:0] addr);
      wr_dec_t d;
      d.mask = cs & ~wr_n & (addr == ADDR_IRQMASK);
      d.cap  = cs & ~wr_n & (addr == ADDR_EDGECAP);
      return d;
   endfunction

   function automatic logic edge_hit(input int   edge_type,
                                     input logic cur,
                                     input logic prev);
      case (edge_type)
         EDGE_RISE: return cur & ~prev;
         EDGE_FALL: return ~cur & prev;
         default:   return cur ^ prev;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pio_in_edge_irq_if.sv
`default_nettype none
// =====================================================================
// pio_in_edge_irq_if : Avalon-MM slave bundle of the input PIO
// Revision           : 1.0
// =====================================================================
interface pio_in_edge_irq_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );

endinterface
`default_nettype wire

// File: rtl/pio_in_debounce.sv
`default_nettype none
// =====================================================================
// pio_in_debounce : one input bit - 2-flop synchroniser, start-up
//                   priming and optional stability counter.
// Revision        : 1.0
// =====================================================================
module pio_in_debounce
   import pio_in_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic pin,
   output logic      debounced,
   output logic      primed
);

   localparam int c_cnt_w = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(DEBOUNCE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   prime_state_e       r_state;
   prime_state_e       w_state_nxt;
   logic               w_load;
   logic               r_s1;
   logic               r_s2;
   logic               r_deb;
   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= PRIME_S1;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         PRIME_S1:   w_state_nxt = PRIME_S2;
         PRIME_S2:   w_state_nxt = PRIME_LOAD;
         PRIME_LOAD: begin
            w_state_nxt = PRIME_RUN;
            w_load      = 1'b1;
         end
         default:    w_state_nxt = PRIME_RUN;
      endcase
   end

   // The value changes on the (D+1)th consecutive mismatching sample,
   // so the filter adds exactly D edges over the unfiltered path.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_deb <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= pin;
         r_s2 <= r_s1;
         if (w_load) begin
            r_deb <= r_s2;
            r_cnt <= '0;
         end else if (r_state != PRIME_RUN) begin
            r_cnt <= '0;
         end else if (DEBOUNCE_CYCLES == 0) begin
            r_deb <= r_s2;
         end else if (r_s2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == c_limit) begin
            r_deb <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

   assign debounced = r_deb;
   assign primed    = (r_state == PRIME_RUN);

endmodule
`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// =====================================================================
// pio_in_edge_irq : Avalon-MM input PIO with per-bit edge capture
//                   (write-1-to-clear), interrupt mask and level IRQ.
// Revision        : 1.0
// =====================================================================
module pio_in_edge_irq
   import pio_in_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0,
   parameter int IRQ_EN          = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [WIDTH-1:0] in_port,
   pio_in_edge_irq_if.slave      bus
);

   logic [WIDTH-1:0] w_deb;
   logic [WIDTH-1:0] w_primed;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_deb_prev;
   logic [WIDTH-1:0] r_primed_prev;
   logic [WIDTH-1:0] r_cap;
   logic [WIDTH-1:0] r_mask;
   logic [31:0]      w_rd_mux;
   logic [31:0]      r_readdata;
   logic             r_irq;
   wr_dec_t          w_wr;
   logic             w_unused;

   // The priming edge loads the pin value without looking like an edge.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         pio_in_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .pin       (in_port[gi]),
            .debounced (w_deb[gi]),
            .primed    (w_primed[gi])
         );
         assign w_edge[gi] = r_primed_prev[gi] & edge_hit(EDGE_TYPE, w_deb[gi], r_deb_prev[gi]);
      end
   endgenerate

   assign w_wr  = wr_decode(bus.chipselect, bus.write_n, bus.address);
   assign w_clr = w_wr.cap ? bus.writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_deb_prev    <= '0;
         r_primed_prev <= '0;
         r_cap         <= '0;
      end else begin
         r_deb_prev    <= w_deb;
         r_primed_prev <= w_primed;
         r_cap         <= w_edge | (r_cap & ~w_clr);
      end
   end

   generate
      if (IRQ_EN != 0) begin : g_irq
         always_ff @(posedge clk) begin
            if (reset) begin
               r_mask <= '0;
               r_irq  <= 1'b0;
            end else begin
               if (w_wr.mask) begin
                  r_mask <= bus.writedata[WIDTH-1:0];
               end
               r_irq <= |(r_cap & r_mask);
            end
         end
      end else begin : g_no_irq
         always_ff @(posedge clk) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
         end
      end
   endgenerate

   always_comb begin
      w_rd_mux = '0;
      case (bus.address)
         ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_deb;
         ADDR_RSVD:    w_rd_mux            = '0;
         ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_mask;
         ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_cap;
         default:      w_rd_mux            = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_mux;
      end
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = r_irq;

   // Upper write-data bits (and the mask strobe when IRQ_EN=0) go nowhere.
   assign w_unused = ^{1'b0, bus.writedata, w_wr};

endmodule
`default_nettype wire
